mem_xfer_ctrl: RTL and testbench

//  Sequencer for memory-to-memory block copy over one single-port RAM.

---
 rtl/mem_xfer_pkg.sv | 16 +
 rtl/xfer_addr_gen.sv | 62 ++++++
 rtl/mem_xfer_ctrl.sv | 116 +++++++++++
 tb/tb_mem_xfer_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared widths and state encoding for the block-copy sequencer
package mem_xfer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/xfer_addr_gen.sv
// rtl/xfer_addr_gen.sv - source/destination pointers, remaining count and progress counter
module xfer_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [LEN_W-1:0]  xfer_cnt,
  output logic              last
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  // Pointers wrap naturally at the address width.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load) begin
      src_d = src_base;
      dst_d = dst_base;
      rem_d = len;
      cnt_d = '0;
    end else if (step) begin
      src_d = src_q + ADDR_W'(1);
      dst_d = dst_q + ADDR_W'(1);
      rem_d = rem_q - LEN_W'(1);
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_ptr  = src_q;
  assign dst_ptr  = dst_q;
  assign xfer_cnt = cnt_q;
  assign last     = (rem_q == LEN_W'(1));

endmodule

// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - read/capture/write sequencer for memory-to-memory copy on one RAM
module mem_xfer_ctrl #(
  parameter int DATA_W = mem_xfer_pkg::DATA_W,
  parameter int ADDR_W = mem_xfer_pkg::ADDR_W,
  parameter int LEN_W  = mem_xfer_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mux_a,
  output logic [ADDR_W-1:0] mux_b,
  output logic              mux_sel,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  xfer_cnt
);

  import mem_xfer_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load, step, last;

  xfer_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .src_ptr  (mux_a),
    .dst_ptr  (mux_b),
    .xfer_cnt (xfer_cnt),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: state_d = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          data_d  = mem_rdata;
          state_d = ST_WRITE;
        end
      end
      // An aborted write still strobes the bus but leaves pointers and count alone.
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          step    = 1'b1;
          state_d = last ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    mux_sel   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_READ: begin
        mux_sel = 1'b1;
        mem_re  = 1'b1;
      end
      ST_WAIT:  mux_sel = 1'b1;
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = data_q;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - self-checking bench for mem_xfer_ctrl with RAM and copy model
module tb_mem_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_base = '0, dst_base = '0, len = '0;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mux_a, mux_b, mem_wdata, xfer_cnt;
  logic       mux_sel, mem_re, mem_we, busy, done;

  mem_xfer_ctrl #(.DATA_W(8), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len), .mem_rdata(mem_rdata),
    .mux_a(mux_a), .mux_b(mux_b), .mux_sel(mux_sel), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  logic [7:0] exp_ram [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;
  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];
  wire  [7:0] ram_addr = mux_sel ? mux_a : mux_b;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) begin
      ram[ram_addr] <= mem_wdata;
      wr_log.push_back(ram_addr);
    end
    if (mem_re) begin
      mem_rdata <= ram[ram_addr];
      rd_log.push_back(ram_addr);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    int         done_cyc;
    logic [7:0] cnt;
  } vec_t;

  vec_t tv [7];

  task automatic bd_write(input logic [7:0] a, input logic [7:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    exp_ram[a] = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Expected strobes in cycle c of an L-word run: READ at 3k+1, WAIT 3k+2, WRITE 3k+3, DONE 3L+1.
  function automatic logic [4:0] exp_strobes(input int c, input int l);
    exp_strobes = {c <= 3*l+1, c == 3*l+1, (c <= 3*l) && (c % 3 == 1),
                   (c <= 3*l) && (c % 3 == 0), (c <= 3*l) && (c % 3 != 0)};
  endfunction

  task automatic chk_logs(input string tag, input int rb, input int wb, input logic [7:0] s,
                          input logic [7:0] d, input int nrd, input int nwr);
    if (chk({tag, " rd_count"}, 64'(rd_log.size() - rb), 64'(nrd)))
      for (int k = 0; k < nrd; k++)
        if (!chk({tag, " rd_addr"}, rd_log[rb+k], 8'(s + k))) break;
    if (chk({tag, " wr_count"}, 64'(wr_log.size() - wb), 64'(nwr)))
      for (int k = 0; k < nwr; k++)
        if (!chk({tag, " wr_addr"}, wr_log[wb+k], 8'(d + k))) break;
    for (int i = 0; i < 256; i++)
      if (!chk({tag, " ram"}, {i[7:0], ram[i]}, {i[7:0], exp_ram[i]})) break;
  endtask

  task automatic do_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input int exp_done, input logic [7:0] exp_cnt, input string tag);
    int rb, wb, done_at, nl;
    bit terr;
    rb = rd_log.size(); wb = wr_log.size(); done_at = -1; terr = 1'b0; nl = int'(l);
    for (int k = 0; k < nl; k++) exp_ram[8'(d + k)] = exp_ram[8'(s + k)];
    src_base = s; dst_base = d; len = l; start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    for (int c = 1; c <= 3*nl+2; c++) begin
      if (done) done_at = c;
      if (!terr && !chk({tag, " timing"}, {busy, done, mem_re, mem_we, mux_sel}, exp_strobes(c, nl)))
        terr = 1'b1;
      if (c <= 3*nl+1) begin
        start    = (c == 4) || ($urandom_range(0, 3) == 0);
        src_base = 8'h80;
        dst_base = 8'($urandom);
        len      = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    void'(chk({tag, " done_cycle"}, 64'(done_at), 64'(exp_done)));
    void'(chk({tag, " xfer_cnt"}, xfer_cnt, exp_cnt));
    chk_logs(tag, rb, wb, s, d, nl, nl);
  endtask

  task automatic do_abort(input logic [7:0] s, input logic [7:0] d, input int l, input int a,
                          input string tag);
    int rb, wb, done_at;
    bit terr;
    rb = rd_log.size(); wb = wr_log.size(); done_at = -1; terr = 1'b0;
    for (int k = 0; k < a/3; k++) exp_ram[8'(d + k)] = exp_ram[8'(s + k)];
    src_base = s; dst_base = d; len = 8'(l); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= a+3; c++) begin
      if (done) done_at = c;
      if (!terr && !chk({tag, " timing"}, {busy, done, mem_re, mem_we, mux_sel},
                        (c <= a) ? exp_strobes(c, l) : 5'b0))
        terr = 1'b1;
      abort = (c == a);
      @(negedge clk);
    end
    abort = 1'b0;
    void'(chk({tag, " no_done"}, 64'(done_at), -64'sd1));
    void'(chk({tag, " xfer_cnt"}, xfer_cnt, 8'((a - 1) / 3)));
    chk_logs(tag, rb, wb, s, d, (a + 2) / 3, a / 3);
  endtask

  task automatic do_reset(input logic [7:0] s, input logic [7:0] d, input int l, input int r,
                          input string tag);
    int wb;
    wb = wr_log.size();
    for (int k = 0; k < r/3; k++) exp_ram[8'(d + k)] = exp_ram[8'(s + k)];
    src_base = s; dst_base = d; len = 8'(l); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= r; c++) begin
      rst = (c == r);
      if (c < r) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    void'(chk({tag, " outputs_zero"},
              {mux_a, mux_b, mux_sel, mem_re, mem_we, mem_wdata, busy, done, xfer_cnt}, '0));
    repeat (3) @(negedge clk);
    void'(chk({tag, " idle_after"}, {busy, mem_re, mem_we, done, xfer_cnt}, '0));
    void'(chk({tag, " wr_count"}, 64'(wr_log.size() - wb), 64'(r / 3)));
    for (int i = 0; i < 256; i++)
      if (!chk({tag, " ram"}, {i[7:0], ram[i]}, {i[7:0], exp_ram[i]})) break;
  endtask

  initial begin
    tv[0] = '{src: 8'h0A, dst: 8'h28, len: 8'd3,   done_cyc: 10,  cnt: 8'd3};
    tv[1] = '{src: 8'h05, dst: 8'h06, len: 8'd0,   done_cyc: 1,   cnt: 8'd0};
    tv[2] = '{src: 8'hFE, dst: 8'hFD, len: 8'd3,   done_cyc: 10,  cnt: 8'd3};
    tv[3] = '{src: 8'h20, dst: 8'h30, len: 8'd2,   done_cyc: 7,   cnt: 8'd2};
    tv[4] = '{src: 8'hFF, dst: 8'h00, len: 8'd1,   done_cyc: 4,   cnt: 8'd1};
    tv[5] = '{src: 8'h50, dst: 8'h51, len: 8'd5,   done_cyc: 16,  cnt: 8'd5};
    tv[6] = '{src: 8'h00, dst: 8'h80, len: 8'd255, done_cyc: 766, cnt: 8'd255};

    @(negedge clk);
    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
    bd_write(8'h0A, 8'hA1);
    bd_write(8'h0B, 8'hB2);
    bd_write(8'h0C, 8'hC3);
    void'(chk("reset outputs",
              {mux_a, mux_b, mux_sel, mem_re, mem_we, mem_wdata, busy, done, xfer_cnt}, '0));
    rst = 1'b0;
    @(negedge clk);
    void'(chk("idle after reset", {busy, done, mem_re, mem_we}, '0));

    for (int i = 0; i < 7; i++) begin
      do_xfer(tv[i].src, tv[i].dst, tv[i].len, tv[i].done_cyc, tv[i].cnt, $sformatf("vec%0d", i));
      if (i == 0)
        void'(chk("basic copy", {ram[8'h28], ram[8'h29], ram[8'h2A]}, 24'hA1B2C3));
    end

    do_abort(8'h60, 8'h70, 4, 5, "abort_wait");
    do_abort(8'h61, 8'h71, 4, 6, "abort_write");
    do_abort(8'h62, 8'h72, 4, 1, "abort_read");
    do_reset(8'h90, 8'hA0, 4, 7, "reset_mid");

    for (int n = 0; n < 10; n++) begin
      logic [7:0] s, d, l;
      s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 20));
      do_xfer(s, d, l, 3*int'(l)+1, l, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
